pipe_skid_buf: RTL and testbench
================================

Name: pipe_skid_buf

Overview:
- Elastic pipeline register with a valid/ready handshake, placed between GPU pipeline stages (e.g. decode->issue, issue->ALU).
- Feeds the bare flop banks downstream. Lets a stall propagate back one stage per cycle without any combinational ready path.
- Main register plus one skid register: full throughput of 1 transfer/cycle, 1-cycle latency.
- Synchronous flush for wavefront squash.

Parameters:
- WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset. rst=0 clears all state immediately; release is synchronous to clk.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  buffer can accept. Driven directly from a register.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload at the head of the buffer.
- occupancy  output  2  entries held, 0..2.

Behaviour:
- Storage:
  - Main register: main_vld, main_dat drive out_valid and out_data.
  - Skid register: skid_vld, skid_dat.
- States:
  - EMPTY: main=0, skid=0.
  - BUSY: main=1, skid=0.
  - FULL: main=1, skid=1.
  - Encoding is in the shared package. occupancy = 0/1/2 respectively.
- Handshakes:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - in_ready = ~skid_vld, registered. Deasserts only in FULL.
  - An upstream holding in_valid while in_ready=0 must keep in_data stable.
- Transitions (flush=0):
  - EMPTY, in xfer -> BUSY; main_dat <= in_data.
  - BUSY, in xfer and out xfer -> BUSY; main_dat <= in_data.
  - BUSY, in xfer only -> FULL; skid_dat <= in_data.
  - BUSY, out xfer only -> EMPTY.
  - FULL, out xfer -> BUSY; main_dat <= skid_dat. No input is possible because in_ready=0.
  - No transfer -> hold state and data.
- Ordering: strict FIFO. Skid content always leaves before any newer input.
- Latency: an input accepted at edge N is visible on out_data after edge N when the buffer was EMPTY or draining.
- flush:
  - flush=1 at an edge -> EMPTY, in_ready=1, occupancy=0.
  - Flush dominates a simultaneous in xfer; that input is dropped.
  - An out xfer in the flush cycle still completes from the downstream view. Producer/consumer own the squash semantics.
- Reset:
  - rst=0 at any time, including mid-transfer: main_vld=0, skid_vld=0, in_ready=1, out_valid=0, occupancy=0.
  - out_data and skid_dat are not reset; their values are don't-care while the corresponding valid is 0.
  - No transfer is recorded while rst=0.
- Boundaries:
  - out_ready=1 while EMPTY: no effect.
  - in_valid=0 with in_ready=1: no effect.
  - out_valid never drops without an out xfer, flush or reset.
  - out_data is stable while out_valid=1 and out_ready=0.
- Assertions (sim only):
  - occupancy never reaches 3.
  - skid_vld implies main_vld.

Decomposition:
- Shared definitions file (alongside the global definitions): state encodings SKB_EMPTY=2'd0, SKB_BUSY=2'd1, SKB_FULL=2'd2.
- One sub-module is natural: dff_en. It is a WIDTH-wide load-enabled data register with no reset, instantiated twice (main, skid).
- Control valids live in the top with the async active-low reset.

Test Plan:
- Reset then stream: rst 0->1; in_valid=1 every cycle with data 0x1..0x8; out_ready=1 -> out_data shows 0x1..0x8 one cycle after each input, occupancy stays 1, in_ready is constantly 1.
- Backpressure: stream 0xA0,0xA1,0xA2 with out_ready=0 -> occupancy 1 then 2, in_ready=0 after 0xA1, 0xA2 held at input; raise out_ready -> outputs 0xA0,0xA1,0xA2 in order, no loss or duplication.
- Random valid/ready: 10k cycles of random toggling against a scoreboard FIFO -> identical ordered stream, out_data stable whenever out_valid=1 and out_ready=0.
- Flush in FULL: hold 0xB0,0xB1, then flush=1 with in_valid=1, data 0xB2 -> next cycle occupancy=0, out_valid=0, in_ready=1, 0xB2 never appears at the output.
- Async reset mid-stream: rst=0 between clock edges while FULL -> out_valid and occupancy go to 0 immediately without a clock edge; after release the stream 0xC0.. passes normally.

Source files
------------

// File: rtl/pipe_skid_buf_pkg.sv
// Shared definitions for the skid buffer: state encoding and the mapping
// from the two control valids onto that encoding.
package pipe_skid_buf_pkg;

    typedef enum logic [1:0] {
        SKB_EMPTY = 2'd0,
        SKB_BUSY  = 2'd1,
        SKB_FULL  = 2'd2
    } skb_state_e;

    // The skid register only fills behind a valid main register.
    function automatic skb_state_e skb_state_of(input logic main_vld, input logic skid_vld);
        if (skid_vld) begin
            return SKB_FULL;
        end else if (main_vld) begin
            return SKB_BUSY;
        end
        return SKB_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_buf_dff_en.sv
// Load-enabled payload register with no reset; its contents are qualified
// by a separate valid flop held in the parent.
module pipe_skid_buf_dff_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (en) begin
            dat_q <= d;
        end
    end

    assign q = dat_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic pipeline register (main + skid) with a registered
// in_ready, so stalls travel upstream one stage per cycle.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic             main_en, skid_en, main_from_skid;
    logic             in_xfer, out_xfer;
    logic [WIDTH-1:0] main_dat_d, main_dat_q, skid_dat_q;
    skb_state_e       state;

    assign state    = skb_state_of(main_vld_q, skid_vld_q);
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_vld_q & out_ready;

    always_comb begin
        main_vld_d     = main_vld_q;
        skid_vld_d     = skid_vld_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            SKB_EMPTY: begin
                if (in_xfer) begin
                    main_vld_d = 1'b1;
                    main_en    = 1'b1;
                end
            end
            SKB_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_vld_d = 1'b1;
                    skid_en    = 1'b1;
                end else if (out_xfer) begin
                    main_vld_d = 1'b0;
                end
            end
            SKB_FULL: begin
                // in_ready is low here, so only the skid entry can advance.
                if (out_xfer) begin
                    skid_vld_d     = 1'b0;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                main_vld_d = 1'b0;
                skid_vld_d = 1'b0;
            end
        endcase
        // Flush wins over any input arriving in the same cycle.
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
        in_ready_d = ~skid_vld_d;
    end

    assign main_dat_d = main_from_skid ? skid_dat_q : in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_buf_dff_en #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .en  (main_en),
        .d   (main_dat_d),
        .q   (main_dat_q)
    );

    pipe_skid_buf_dff_en #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_dat_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_dat_q;
    assign occupancy = state;

    a_occ_max: assert property (@(posedge clk) disable iff (!rst) occupancy != 2'd3);
    a_skid_main: assert property (@(posedge clk) disable iff (!rst) !skid_vld_q || main_vld_q);

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Scoreboard bench for pipe_skid_buf: directed scenarios plus a long random
// valid/ready run checked against a two-entry FIFO model.
module tb_pipe_skid_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_skid_buf #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Booking: one unit before the edge, record what the coming edge accepts.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // Monitor: compares the DUT against the model contents, pops on output transfers.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            chk("occupancy", {30'd0, occupancy}, exp_q.size());
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                chk("out_data_held", out_data, exp_q[0]);
            end
        end
    end

    // Called right after a negedge; returns right after the negedge following acceptance.
    task automatic send(input logic [31:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic pending;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_occ", {30'd0, occupancy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Full-rate stream
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(i);
        drain();

        // Backpressure into FULL, then release
        out_ready = 1'b0;
        send(32'hA0);
        send(32'hA1);
        in_valid = 1'b1;
        in_data  = 32'hA2;
        repeat (3) @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_head", out_data, 32'hA0);
        out_ready = 1'b1;
        send(32'hA2);
        drain();

        // Flush while FULL with a simultaneous input
        out_ready = 1'b0;
        send(32'hB0);
        send(32'hB1);
        in_valid = 1'b1;
        in_data  = 32'hB2;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_no_b2", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0;
        send(32'hD0);
        send(32'hD1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_occ", {30'd0, occupancy}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(32'hC0 + i);
        drain();

        // Random valid/ready with occasional flush
        pending = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            pending   = in_valid && !in_ready && !flush;
            @(negedge clk);
        end
        flush = 1'b0;
        drain();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
